// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream
//
// Turns the read side of a normal-mode FIFO (data valid one cycle after the
// read request) into a valid/ready stream. A two-entry in-order skid buffer
// absorbs the one-cycle read latency, so full throughput is sustained while
// out_valid_o/out_data_o come straight from registers.
//
// Ports
//   clock         sole clock, rising edge
//   sclr          synchronous active-high clear
//   fifo_empty_i  FIFO empty flag
//   fifo_q_i      FIFO read data, valid the cycle after fifo_rdreq_o
//   fifo_rdreq_o  FIFO read request (combinational)
//   out_data_o    stream data (buffer head)
//   out_valid_o   stream valid (buffer non-empty)
//   out_ready_i   downstream ready
//   rd_count_o    words delivered on the stream since reset (wraps)
// ---------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int DWIDTH = 8,
    parameter int CNTW   = 16
) (
    input  logic              clock,
    input  logic              sclr,
    input  logic              fifo_empty_i,
    input  logic [DWIDTH-1:0] fifo_q_i,
    output logic              fifo_rdreq_o,
    output logic [DWIDTH-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CNTW-1:0]   rd_count_o
);

    logic [DWIDTH-1:0] buf_mem [0:1];
    logic [1:0]        occ_reg;
    logic [1:0]        occ_next;
    logic              inflight_reg;
    logic              head_reg;
    logic              tail_reg;
    logic [CNTW-1:0]   count_reg;
    logic              pop;
    logic [1:0]        pending;

    // pending = words that will be held after this edge without a new
    // request: buffered plus in flight, minus the one leaving now. The
    // invariant occ + inflight <= 2 keeps this within two bits.
    always_comb begin
        pop          = (occ_reg != 2'd0) & out_ready_i;
        pending      = occ_reg + {1'b0, inflight_reg} - {1'b0, pop};
        occ_next     = pending;
        fifo_rdreq_o = ~sclr & ~fifo_empty_i & (pending < 2'd2);
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            occ_reg      <= 2'd0;
            inflight_reg <= 1'b0;
            head_reg     <= 1'b0;
            tail_reg     <= 1'b0;
            count_reg    <= '0;
        end else begin
            occ_reg      <= occ_next;
            inflight_reg <= fifo_rdreq_o;
            if (inflight_reg) begin
                tail_reg <= ~tail_reg;
            end
            if (pop) begin
                head_reg  <= ~head_reg;
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    // Buffer storage needs no clear: entries are only read once occ marks
    // them as holding a word.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (inflight_reg && (tail_reg == 1'(gi))) begin
                    buf_mem[gi] <= fifo_q_i;
                end
            end
        end
    endgenerate

    assign out_valid_o = (occ_reg != 2'd0);
    assign out_data_o  = buf_mem[head_reg];
    assign rd_count_o  = count_reg;

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

    logic        clock = 1'b0;
    logic        sclr  = 1'b1;
    logic        fifo_empty;
    logic [7:0]  fifo_q = 8'd0;
    logic        fifo_rdreq;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] rd_count;

    // second instance with a narrow counter for the wrap test
    logic        empty2;
    logic [7:0]  q2 = 8'd0;
    logic        rdreq2;
    logic [7:0]  data2;
    logic        valid2;
    logic        ready2 = 1'b1;
    logic [3:0]  cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    // FIFO model: tasks write, the clocked process reads
    logic [7:0] fifo_mem [0:255];
    int fifo_wr = 0;
    int fifo_rd = 0;
    int rdreq_cnt = 0;
    int underflow = 0;
    logic [7:0] got[$];

    int total2 = 0;
    int taken2 = 0;

    assign fifo_empty = (fifo_rd == fifo_wr);
    assign empty2     = (taken2 == total2);

    always #5 clock = ~clock;

    fifo_rd_stream #(.DWIDTH(8), .CNTW(16)) dut (
        .clock(clock), .sclr(sclr), .fifo_empty_i(fifo_empty), .fifo_q_i(fifo_q),
        .fifo_rdreq_o(fifo_rdreq), .out_data_o(out_data), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .rd_count_o(rd_count)
    );

    fifo_rd_stream #(.DWIDTH(8), .CNTW(4)) dut2 (
        .clock(clock), .sclr(sclr), .fifo_empty_i(empty2), .fifo_q_i(q2),
        .fifo_rdreq_o(rdreq2), .out_data_o(data2), .out_valid_o(valid2),
        .out_ready_i(ready2), .rd_count_o(cnt2)
    );

    always @(posedge clock) begin
        if (fifo_rdreq) begin
            fifo_q    <= fifo_mem[fifo_rd % 256];
            fifo_rd   <= fifo_rd + 1;
            rdreq_cnt <= rdreq_cnt + 1;
            if (fifo_empty) underflow <= underflow + 1;
        end
        if (!sclr && out_valid && out_ready) got.push_back(out_data);
        if (rdreq2) begin
            q2     <= 8'(taken2 + 1);
            taken2 <= taken2 + 1;
        end
    end

    task automatic load(input int first, input int n);
        for (int k = 0; k < n; k++) begin
            fifo_mem[fifo_wr % 256] = 8'(first + k);
            fifo_wr = fifo_wr + 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        sclr = 1'b1;
        fifo_wr = fifo_rd;
        @(negedge clock);
        sclr = 1'b0;
    endtask

    task automatic test_reset();
        load(100, 1);
        @(negedge clock);
        n_cmp++;
        if (fifo_rdreq !== 1'b0) begin
            n_bad++; $display("FAIL reset_rdreq: got %b want 0", fifo_rdreq);
        end
        fifo_wr = fifo_rd;
        @(negedge clock);
        n_cmp++;
        if (out_valid !== 1'b0 || rd_count !== 16'd0) begin
            n_bad++; $display("FAIL reset_state: valid=%b count=%0d want 0/0", out_valid, rd_count);
        end
        $display("test_reset done");
    endtask

    task automatic test_idle();
        sclr = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            n_cmp++;
            if (fifo_rdreq !== 1'b0 || out_valid !== 1'b0 || rd_count !== 16'd0) begin
                n_bad++;
                $display("FAIL idle_c%0d: rdreq=%b valid=%b count=%0d want 0/0/0", c, fifo_rdreq, out_valid, rd_count);
            end
        end
        $display("test_idle done");
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        out_ready = 1'b1;
        base = rdreq_cnt;
        load(1, 8);
        #1;
        n_cmp++;
        if (fifo_rdreq !== 1'b1) begin
            n_bad++; $display("FAIL b2b_first_rdreq: got %b want 1", fifo_rdreq);
        end
        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 8'(i + 1) || rd_count !== 16'(i)) begin
                n_bad++;
                $display("FAIL b2b_word%0d: valid=%b data=%0d count=%0d want 1/%0d/%0d", i, out_valid, out_data, rd_count, i + 1, i);
            end
            @(negedge clock);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || rd_count !== 16'd8 || (rdreq_cnt - base) !== 8 || underflow !== 0) begin
            n_bad++;
            $display("FAIL b2b_end: valid=%b count=%0d reads=%0d underflow=%0d want 0/8/8/0", out_valid, rd_count, rdreq_cnt - base, underflow);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_stall();
        int base;
        int gbase;
        bit stable;
        do_reset();
        out_ready = 1'b0;
        base = rdreq_cnt;
        load(1, 5);
        stable = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (c >= 2 && (out_valid !== 1'b1 || out_data !== 8'd1)) stable = 1'b0;
        end
        n_cmp++;
        if ((rdreq_cnt - base) !== 2) begin
            n_bad++; $display("FAIL stall_reads: got %0d want 2", rdreq_cnt - base);
        end
        n_cmp++;
        if (!stable || out_valid !== 1'b1 || out_data !== 8'd1) begin
            n_bad++; $display("FAIL stall_hold: valid=%b data=%0d stable=%b want 1/1/1", out_valid, out_data, stable);
        end
        gbase = got.size();
        out_ready = 1'b1;
        repeat (10) @(negedge clock);
        n_cmp++;
        if (got.size() - gbase !== 5 || rd_count !== 16'd5) begin
            n_bad++; $display("FAIL stall_count: words=%0d count=%0d want 5/5", got.size() - gbase, rd_count);
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (got[gbase + k] !== 8'(k + 1)) begin
                    n_bad++; $display("FAIL stall_order%0d: got %0d want %0d", k, got[gbase + k], k + 1);
                end
            end
        end
        $display("test_stall done");
    endtask

    task automatic test_toggle();
        int base;
        int gbase;
        int outstanding;
        int max_out;
        do_reset();
        base = rdreq_cnt;
        gbase = got.size();
        max_out = 0;
        load(1, 6);
        for (int c = 0; c < 20; c++) begin
            out_ready = (c % 2 == 0);
            @(negedge clock);
            outstanding = (rdreq_cnt - base) - (got.size() - gbase);
            if (outstanding > max_out) max_out = outstanding;
        end
        out_ready = 1'b1;
        repeat (4) @(negedge clock);
        n_cmp++;
        if (max_out > 2) begin
            n_bad++; $display("FAIL toggle_occ: max held %0d want <=2", max_out);
        end
        n_cmp++;
        if (got.size() - gbase !== 6 || rd_count !== 16'd6) begin
            n_bad++; $display("FAIL toggle_count: words=%0d count=%0d want 6/6", got.size() - gbase, rd_count);
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++;
                if (got[gbase + k] !== 8'(k + 1)) begin
                    n_bad++; $display("FAIL toggle_order%0d: got %0d want %0d", k, got[gbase + k], k + 1);
                end
            end
        end
        $display("test_toggle done");
    endtask

    task automatic test_midreset();
        int gbase;
        bit seen;
        do_reset();
        out_ready = 1'b1;
        gbase = got.size();
        load(1, 8);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clock);
            if (out_valid === 1'b1 && out_data === 8'd3) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL midrst_word3: word 3 not seen within 10 cycles, want seen");
        end
        @(negedge clock);
        sclr = 1'b1;
        fifo_wr = fifo_rd;
        #1;
        n_cmp++;
        if (fifo_rdreq !== 1'b0) begin
            n_bad++; $display("FAIL midrst_rdreq: got %b want 0", fifo_rdreq);
        end
        @(negedge clock);
        n_cmp++;
        if (out_valid !== 1'b0 || rd_count !== 16'd0) begin
            n_bad++; $display("FAIL midrst_clear: valid=%b count=%0d want 0/0", out_valid, rd_count);
        end
        sclr = 1'b0;
        n_cmp++;
        if (got.size() - gbase !== 3) begin
            n_bad++; $display("FAIL midrst_pre: words=%0d want 3", got.size() - gbase);
        end
        gbase = got.size();
        load(9, 2);
        repeat (6) @(negedge clock);
        n_cmp++;
        if (got.size() - gbase !== 2 || rd_count !== 16'd2) begin
            n_bad++; $display("FAIL midrst_refill: words=%0d count=%0d want 2/2", got.size() - gbase, rd_count);
        end else begin
            n_cmp++;
            if (got[gbase] !== 8'd9 || got[gbase + 1] !== 8'd10) begin
                n_bad++; $display("FAIL midrst_data: got %0d,%0d want 9,10", got[gbase], got[gbase + 1]);
            end
        end
        $display("test_midreset done");
    endtask

    task automatic test_wrap();
        ready2 = 1'b1;
        total2 = total2 + 17;
        repeat (25) @(negedge clock);
        n_cmp++;
        if (cnt2 !== 4'd1 || valid2 !== 1'b0 || taken2 !== 17) begin
            n_bad++; $display("FAIL wrap_count: count=%0d valid=%b reads=%0d want 1/0/17", cnt2, valid2, taken2);
        end
        $display("test_wrap done");
    endtask

    initial begin
        test_reset();
        test_idle();
        test_back_to_back();
        test_stall();
        test_toggle();
        test_midreset();
        test_wrap();
        n_cmp++;
        if (underflow !== 0) begin
            n_bad++; $display("FAIL underflow: got %0d want 0", underflow);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
